// File: rtl/eth_frame_gen.sv
// Ethernet frame generator feeding the 1G MAC TX AXI-Stream: 14-byte header, counting payload, idle gap.
// Optional ETH_FRAME_GEN_SEQNUM_EN puts the frame number in the first four payload bytes.
module eth_frame_gen #(
    parameter int PAYLOAD_W = 11,
    parameter int GAP_W     = 16
) (
    input  logic                 gtx_clk,
    input  logic                 gtx_rst,
    input  logic                 enable,
    input  logic [47:0]          dst_mac,
    input  logic [47:0]          src_mac,
    input  logic [15:0]          ethertype,
    input  logic [PAYLOAD_W-1:0] payload_len,
    input  logic [GAP_W-1:0]     gap_cycles,
    output logic                 busy,
    output logic [31:0]          frame_count,
    output logic [7:0]           tx_axis_tdata,
    output logic                 tx_axis_tvalid,
    output logic                 tx_axis_tlast,
    output logic                 tx_axis_tuser,
    input  logic                 tx_axis_tready
);

    localparam logic [15:0] MIN_LEN = 16'd46;
    localparam logic [15:0] MAX_LEN = 16'd1500;

    typedef enum logic [1:0] {IDLE, HEADER, PAYLOAD, GAP} state_t;

    state_t             state_q;
    logic [111:0]       hdr_q;
    logic [15:0]        len_q;
    logic [15:0]        idx_q;
    logic [GAP_W-1:0]   gap_q;
    logic [GAP_W-1:0]   gapCnt_q;
    logic [7:0]         tdata_q;
    logic               tvalid_q;
    logic               tlast_q;
    logic               busy_q;
    logic [31:0]        frameCount_q;

    logic [15:0]        lenExt_d;
    logic [15:0]        lenClamp_d;
    logic [15:0]        idxNext_d;
    logic [7:0]         payNext_d;
    logic [7:0]         payFirst_d;
    logic               handshake_d;

    assign lenExt_d    = 16'(payload_len);
    assign lenClamp_d  = (lenExt_d < MIN_LEN) ? MIN_LEN :
                         (lenExt_d > MAX_LEN) ? MAX_LEN : lenExt_d;
    assign idxNext_d   = idx_q + 16'd1;
    assign handshake_d = tvalid_q & tx_axis_tready;

`ifdef ETH_FRAME_GEN_SEQNUM_EN
    logic [31:0] seq_q;

    // Frame number as seen at frame start, sent big-endian in payload bytes 0..3.
    always_ff @(posedge gtx_clk or posedge gtx_rst) begin
        if (gtx_rst) begin
            seq_q <= 32'd0;
        end else if (state_q == IDLE && enable) begin
            seq_q <= frameCount_q;
        end
    end

    always_comb begin
        payNext_d = idxNext_d[7:0];
        if (idxNext_d < 16'd4) begin
            case (idxNext_d[1:0])
                2'd1:    payNext_d = seq_q[23:16];
                2'd2:    payNext_d = seq_q[15:8];
                2'd3:    payNext_d = seq_q[7:0];
                default: payNext_d = seq_q[31:24];
            endcase
        end
    end

    assign payFirst_d = seq_q[31:24];
`else
    assign payNext_d  = idxNext_d[7:0];
    assign payFirst_d = 8'h00;
`endif

    // hdr_q holds the header bytes still to be sent, next one in the top byte.
    always_ff @(posedge gtx_clk or posedge gtx_rst) begin
        if (gtx_rst) begin
            state_q      <= IDLE;
            hdr_q        <= '0;
            len_q        <= 16'd0;
            idx_q        <= 16'd0;
            gap_q        <= '0;
            gapCnt_q     <= '0;
            tdata_q      <= 8'h00;
            tvalid_q     <= 1'b0;
            tlast_q      <= 1'b0;
            busy_q       <= 1'b0;
            frameCount_q <= 32'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        state_q  <= HEADER;
                        busy_q   <= 1'b1;
                        hdr_q    <= {dst_mac[39:0], src_mac, ethertype, 8'h00};
                        len_q    <= lenClamp_d;
                        gap_q    <= gap_cycles;
                        idx_q    <= 16'd0;
                        tdata_q  <= dst_mac[47:40];
                        tvalid_q <= 1'b1;
                        tlast_q  <= 1'b0;
                    end
                end
                HEADER: begin
                    if (handshake_d) begin
                        if (idx_q == 16'd13) begin
                            state_q <= PAYLOAD;
                            idx_q   <= 16'd0;
                            tdata_q <= payFirst_d;
                        end else begin
                            idx_q   <= idxNext_d;
                            tdata_q <= hdr_q[111:104];
                            hdr_q   <= {hdr_q[103:0], 8'h00};
                        end
                    end
                end
                PAYLOAD: begin
                    if (handshake_d) begin
                        if (tlast_q) begin
                            frameCount_q <= frameCount_q + 32'd1;
                            tvalid_q     <= 1'b0;
                            tlast_q      <= 1'b0;
                            tdata_q      <= 8'h00;
                            if (gap_q != '0) begin
                                state_q  <= GAP;
                                gapCnt_q <= gap_q;
                            end else begin
                                state_q  <= IDLE;
                                busy_q   <= 1'b0;
                            end
                        end else begin
                            idx_q   <= idxNext_d;
                            tdata_q <= payNext_d;
                            tlast_q <= (idxNext_d == len_q - 16'd1);
                        end
                    end
                end
                GAP: begin
                    if (gapCnt_q == GAP_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        gapCnt_q <= gapCnt_q - GAP_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy           = busy_q;
    assign frame_count    = frameCount_q;
    assign tx_axis_tdata  = tdata_q;
    assign tx_axis_tvalid = tvalid_q;
    assign tx_axis_tlast  = tlast_q;
    assign tx_axis_tuser  = 1'b0;

endmodule

// File: doc/eth_frame_gen.md
# eth_frame_gen

Ethernet frame generator that drives the TX AXI-Stream input of the 1G MAC wrapper. It is the transmit-side counterpart to the MAC's RX stream. It emits back-to-back frames built from a runtime-configured header (destination MAC, source MAC, EtherType), followed by a deterministic payload, with a programmable inter-frame gap. The MAC appends preamble, padding and FCS. This block produces only header plus payload bytes and runs entirely in the MAC's `gtx_clk` domain.

## Interface
- `PAYLOAD_W`, default 11: width of `payload_len`.
- `GAP_W`, default 16: width of `gap_cycles`.

- `gtx_clk`  in  1  MAC transmit clock; all logic is on its rising edge.
- `gtx_rst`  in  1  reset, asynchronous, active-high.
- `enable`  in  1  start and continue generating frames.
- `dst_mac`  in  48  destination MAC; byte [47:40] is sent first.
- `src_mac`  in  48  source MAC; byte [47:40] is sent first.
- `ethertype`  in  16  EtherType; byte [15:8] is sent first.
- `payload_len`  in  PAYLOAD_W  payload bytes per frame, clamped to [46, 1500].
- `gap_cycles`  in  GAP_W  extra idle cycles after each frame.
- `busy`  out  1  high while in any state other than IDLE.
- `frame_count`  out  32  frames completed, counting tlast handshakes.
- `tx_axis_tdata`  out  8  stream byte.
- `tx_axis_tvalid`  out  1  byte valid.
- `tx_axis_tlast`  out  1  last byte of the frame.
- `tx_axis_tuser`  out  1  tied to 0; the block never aborts a frame.
- `tx_axis_tready`  in  1  MAC accepts the byte.

## Operation
- States:
  - IDLE: waits for `enable`.
  - HEADER: sends 14 bytes.
  - PAYLOAD: sends L bytes.
  - GAP: waits `gap_cycles` cycles.
- IDLE → HEADER on a clock edge where `enable`=1. At that edge the block latches `dst_mac`, `src_mac`, `ethertype`, the clamped L and `gap_cycles`. Changes to these inputs mid-frame have no effect on the current frame.
- Clamp rule: L = 46 if `payload_len` < 46; L = 1500 if `payload_len` > 1500; otherwise L = `payload_len`.
- Header byte order: dst_mac[47:40] … dst_mac[7:0], then src_mac[47:40] … src_mac[7:0], then ethertype[15:8], ethertype[7:0].
- Payload byte i (0-based) = i[7:0], so the pattern wraps 0xFF→0x00.
- A 16-bit byte index advances only on a handshake (tvalid & tready).
- Handshake rules:
  - Once tvalid is high, tdata, tlast and tvalid hold until tready.
  - tvalid is never dropped mid-frame.
  - tlast is high only on payload byte L-1.
- On the tlast handshake:
  - `frame_count` increments, wrapping 0xFFFFFFFF→0.
  - Next state is GAP if the latched gap > 0, otherwise IDLE.
- GAP: a down-counter loads the latched gap and goes to IDLE when it reaches 1.
- `enable` deasserted mid-frame: the current frame completes normally, then the block rests in IDLE.
- Reset mid-frame: all outputs clear at once. The truncated frame is reported by the MAC as underflow; this is accepted behaviour.

## Timing
- All outputs are registered.
- Reset values: tvalid=0, tlast=0, tdata=0x00, tuser=0, busy=0, frame_count=0, state=IDLE.
- First byte: tvalid rises the cycle after the edge on which IDLE samples `enable`=1.
- Throughput: 1 byte per cycle while tready=1, so a frame is 14+L handshakes.
- Between frames with `enable` held high, tvalid is low for exactly `gap_cycles`+1 cycles (minimum 1).
- `frame_count` shows its new value the cycle after the tlast handshake.
- `busy` follows the registered state, with no extra latency.

## Configuration
- `ETH_FRAME_GEN_SEQNUM_EN` defined:
  - Payload bytes 0..3 carry the frame_count value latched at frame start, big-endian.
  - Payload bytes from 4 onward follow the i[7:0] pattern, indexed from payload start.
- Not defined: every payload byte follows the i[7:0] pattern, and there is no sequence-number logic.

## Test plan
- Reset, `enable`=1, dst=FF:FF:FF:FF:FF:FF, src=02:00:00:00:00:01, ethertype=0x88B5, L=46, gap=0, tready=1 → 60 bytes with tlast on byte 60; tvalid low for 1 cycle; frame_count=1.
- `payload_len`=10 → clamped to 46; `payload_len`=2000 → 1514 bytes, with payload bytes 256..258 = 00,01,02.
- Random tready stalls (~30% low) → tdata/tlast stable while tvalid=1 and tready=0; byte sequence identical to the no-stall run.
- `gap_cycles`=5 → exactly 6 tvalid-low cycles between tlast and the next first byte (0xFF).
- `enable` dropped at header byte 3 → the frame completes fully, no new frame starts, busy→0; `gtx_rst` pulsed mid-payload → tvalid=0 and frame_count=0 in the same cycle.
- With `ETH_FRAME_GEN_SEQNUM_EN`: third frame's payload bytes 0..3 = 00 00 00 02, and byte 4 = 0x04.
